// File: rtl/dp_fifo_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dp_fifo_pkg                                         |
// | Description : Shared types and default widths for the dual-port  |
// |               EBR FIFO controller.                                |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
package dp_fifo_pkg;

  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_DATA_WIDTH = 4;

  // INIT sweeps the RAM with zero/parity-clean words; READY runs the FIFO.
  typedef enum logic [0:0] {
    ST_INIT  = 1'b0,
    ST_READY = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dp_fifo_parity.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dp_fifo_parity                                      |
// | Description : XOR-reduction tree. Used both to generate the even |
// |               parity bit on write and to check {EDO,Q} on read.   |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module dp_fifo_parity #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] data,
  output logic             parity
);

  // Reduction XOR: 1 when the word holds an odd number of ones.
  assign parity = ^data;

endmodule
`default_nettype wire

// File: rtl/dp_fifo_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : dp_fifo_ctrl                                        |
// | Description : Single-clock FIFO controller for an external       |
// |               16x(4+1) dual-port EBR RAM. Adds even parity on    |
// |               write, checks it on read, and sweeps the RAM clean |
// |               after reset.                                        |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module dp_fifo_ctrl
  import dp_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int AFULL_LEVEL  = 12,
  parameter int AEMPTY_LEVEL = 4
) (
  input  logic                  Clock,
  input  logic                  ResetN,
  input  logic                  Flush,
  input  logic                  Push,
  input  logic [DATA_WIDTH-1:0] PushData,
  input  logic                  Pop,
  output logic [DATA_WIDTH-1:0] PopData,
  output logic                  PopValid,
  output logic                  Full,
  output logic                  Empty,
  output logic                  AlmostFull,
  output logic                  AlmostEmpty,
  output logic [ADDR_WIDTH:0]   Count,
  output logic                  Busy,
  output logic                  Overflow,
  output logic                  Underflow,
  output logic                  ParityErr,
  output logic [ADDR_WIDTH-1:0] WrAddress,
  output logic                  WrEn,
  output logic [DATA_WIDTH-1:0] Data,
  output logic                  EDI,
  output logic [ADDR_WIDTH-1:0] RdAddress,
  output logic                  RdEn,
  input  logic [DATA_WIDTH-1:0] Q,
  input  logic                  EDO
);

  localparam logic [ADDR_WIDTH:0] c_depth  = (ADDR_WIDTH + 1)'(2 ** ADDR_WIDTH);
  localparam logic [ADDR_WIDTH:0] c_afull  = (ADDR_WIDTH + 1)'(AFULL_LEVEL);
  localparam logic [ADDR_WIDTH:0] c_aempty = (ADDR_WIDTH + 1)'(AEMPTY_LEVEL);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_sweep;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_pop_valid;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  r_parity_err;

  logic w_ready;
  logic w_flush;
  logic w_acc_push;
  logic w_acc_pop;
  logic w_gen_parity;
  logic w_chk_err;

  // Status flags come only from registered state, never from Push/Pop.
  assign Busy        = (r_state == ST_INIT);
  assign Full        = Busy | (r_count == c_depth);
  assign Empty       = Busy | (r_count == '0);
  assign AlmostFull  = (r_count >= c_afull);
  assign AlmostEmpty = (r_count <= c_aempty);
  assign Count       = r_count;
  assign PopValid    = r_pop_valid;
  assign PopData     = Q;
  assign Overflow    = r_overflow;
  assign Underflow   = r_underflow;
  assign ParityErr   = r_parity_err;

  // Flush wins over Push/Pop; both are ignored while the sweep runs.
  assign w_ready    = (r_state == ST_READY);
  assign w_flush    = w_ready & Flush;
  assign w_acc_push = w_ready & ~Flush & Push & ~Full;
  assign w_acc_pop  = w_ready & ~Flush & Pop  & ~Empty;

  dp_fifo_parity #(.WIDTH(DATA_WIDTH)) u_par_gen (
    .data   (PushData),
    .parity (w_gen_parity)
  );

  // A clean stored word has even parity across {EDO,Q}.
  dp_fifo_parity #(.WIDTH(DATA_WIDTH + 1)) u_par_chk (
    .data   ({EDO, Q}),
    .parity (w_chk_err)
  );

  // FSM state register.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) r_state <= ST_INIT;
    else         r_state <= w_state_nxt;
  end

  // Next state and RAM port drive.
  always_comb begin
    w_state_nxt = r_state;
    WrEn        = 1'b0;
    WrAddress   = r_wr_ptr;
    Data        = PushData;
    EDI         = w_gen_parity;
    RdEn        = w_acc_pop;
    RdAddress   = r_rd_ptr;
    case (r_state)
      ST_INIT: begin
        WrEn      = 1'b1;
        WrAddress = r_sweep;
        Data      = '0;
        EDI       = 1'b0;
        RdEn      = 1'b0;
        if (r_sweep == '1) w_state_nxt = ST_READY;
      end
      ST_READY: begin
        WrEn = w_acc_push;
      end
      default: w_state_nxt = ST_INIT;
    endcase
  end

  // Sweep address counter; wraps back to 0 as the sweep completes.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN)   r_sweep <= '0;
    else if (Busy) r_sweep <= r_sweep + 1'b1;
  end

  // Pointers and occupancy; simultaneous push and pop holds Count.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_acc_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_acc_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_acc_push, w_acc_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Read-valid pulse, reject pulses and the sticky parity error.
  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_pop_valid  <= 1'b0;
      r_overflow   <= 1'b0;
      r_underflow  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_pop_valid <= w_acc_pop;
      r_overflow  <= w_ready & ~Flush & Push & Full;
      r_underflow <= w_ready & ~Flush & Pop & Empty;
      if (w_flush)                        r_parity_err <= 1'b0;
      else if (r_pop_valid && w_chk_err) r_parity_err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dp_fifo_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module      : tb_dp_fifo_ctrl                                     |
// | Description : Self-checking bench for dp_fifo_ctrl with a RAM    |
// |               model and a queue-based reference model.           |
// | Revision    : 1.0 - initial release                               |
// +------------------------------------------------------------------+
module tb_dp_fifo_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 4;
  localparam int DEPTH = 16;

  logic          Clock = 1'b0;
  logic          ResetN = 1'b0;
  logic          Flush = 1'b0;
  logic          Push = 1'b0;
  logic          Pop = 1'b0;
  logic [DW-1:0] PushData = '0;
  logic [DW-1:0] PopData;
  logic          PopValid, Full, Empty, AlmostFull, AlmostEmpty, Busy;
  logic          Overflow, Underflow, ParityErr, WrEn, EDI, RdEn, EDO;
  logic [AW:0]   Count;
  logic [AW-1:0] WrAddress, RdAddress;
  logic [DW-1:0] Data, Q;

  int checks = 0;
  int errors = 0;

  dp_fifo_ctrl dut (
    .Clock(Clock), .ResetN(ResetN), .Flush(Flush), .Push(Push),
    .PushData(PushData), .Pop(Pop), .PopData(PopData), .PopValid(PopValid),
    .Full(Full), .Empty(Empty), .AlmostFull(AlmostFull),
    .AlmostEmpty(AlmostEmpty), .Count(Count), .Busy(Busy),
    .Overflow(Overflow), .Underflow(Underflow), .ParityErr(ParityErr),
    .WrAddress(WrAddress), .WrEn(WrEn), .Data(Data), .EDI(EDI),
    .RdAddress(RdAddress), .RdEn(RdEn), .Q(Q), .EDO(EDO)
  );

  initial forever #5 Clock = ~Clock;

  // RAM model: registered read, optional EDO corruption.
  logic [DW:0] mem [DEPTH];
  logic [DW:0] ram_out = '0;
  logic        flip_edo = 1'b0;
  always @(posedge Clock) begin
    if (WrEn) mem[WrAddress] <= {EDI, Data};
    if (RdEn) ram_out <= mem[RdAddress];
  end
  assign Q   = ram_out[DW-1:0];
  assign EDO = ram_out[DW] ^ flip_edo;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of words plus a few counters.
  int m_init_left;
  int m_q[$];
  int m_wr, m_rd, m_pd;
  bit m_pv, m_ovf, m_unf, m_perr;

  task automatic model_reset();
    m_init_left = DEPTH;
    m_q.delete();
    m_wr = 0; m_rd = 0; m_pd = 0;
    m_pv = 0; m_ovf = 0; m_unf = 0; m_perr = 0;
  endtask

  task automatic model_step();
    int cnt;
    bit ap, apop;
    cnt = m_q.size();
    if (m_init_left > 0) begin
      m_init_left--;
      m_pv = 0; m_ovf = 0; m_unf = 0;
      return;
    end
    ap   = !Flush && Push && cnt < DEPTH;
    apop = !Flush && Pop && cnt > 0;
    if (Flush) m_perr = 0;
    else if (m_pv && flip_edo) m_perr = 1;
    m_ovf = !Flush && Push && cnt == DEPTH;
    m_unf = !Flush && Pop && cnt == 0;
    m_pv  = apop;
    if (apop) begin m_pd = m_q.pop_front(); m_rd++; end
    if (ap) begin m_q.push_back(int'(PushData)); m_wr++; end
    if (Flush) begin m_q.delete(); m_wr = 0; m_rd = 0; end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge Clock or negedge ResetN);
      if (!ResetN) model_reset();
      else model_step();
    end
  end

  // Every-cycle compare against the model, after inputs settle.
  always @(negedge Clock) begin
    int cnt;
    bit busy, ap, apop;
    #2;
    cnt  = m_q.size();
    busy = m_init_left > 0;
    ap   = !busy && !Flush && Push && cnt < DEPTH;
    apop = !busy && !Flush && Pop && cnt > 0;
    chk("Busy", int'(Busy), int'(busy));
    chk("Count", int'(Count), cnt);
    chk("Full", int'(Full), int'(busy || cnt == DEPTH));
    chk("Empty", int'(Empty), int'(busy || cnt == 0));
    chk("AlmostFull", int'(AlmostFull), int'(cnt >= 12));
    chk("AlmostEmpty", int'(AlmostEmpty), int'(cnt <= 4));
    chk("WrEn", int'(WrEn), int'(busy || ap));
    if (busy) begin
      chk("SweepAddr", int'(WrAddress), DEPTH - m_init_left);
      chk("SweepWord", int'({EDI, Data}), 0);
    end else if (ap) begin
      chk("WrAddress", int'(WrAddress), m_wr % DEPTH);
      chk("Data", int'(Data), int'(PushData));
      chk("EDI", int'(EDI), $countones(PushData) % 2);
    end
    chk("RdEn", int'(RdEn), int'(apop));
    if (apop) chk("RdAddress", int'(RdAddress), m_rd % DEPTH);
    chk("PopValid", int'(PopValid), int'(m_pv));
    if (m_pv) chk("PopData", int'(PopData), m_pd);
    chk("Overflow", int'(Overflow), int'(m_ovf));
    chk("Underflow", int'(Underflow), int'(m_unf));
    chk("ParityErr", int'(ParityErr), int'(m_perr));
  end

  task automatic drive(input bit ps, input bit pp, input logic [DW-1:0] d, input bit fl);
    @(negedge Clock);
    Push = ps; Pop = pp; PushData = d; Flush = fl;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    repeat (2) @(negedge Clock);
    #3;
    chk("rst_Busy", int'(Busy), 1);
    chk("rst_Full", int'(Full), 1);
    chk("rst_Empty", int'(Empty), 1);
    chk("rst_AEmpty", int'(AlmostEmpty), 1);
    chk("rst_Count", int'(Count), 0);
    chk("rst_PopValid", int'(PopValid), 0);
    @(negedge Clock);
    ResetN = 1'b1;
    #3;
    chk("sweep_first_addr", int'(WrAddress), 0);
    idle(15);
    #3;
    chk("sweep_last_busy", int'(Busy), 1);
    chk("sweep_last_addr", int'(WrAddress), 15);
    idle(1);
    #3;
    chk("ready_Busy", int'(Busy), 0);
    chk("ready_Empty", int'(Empty), 1);
    chk("ready_Count", int'(Count), 0);

    // Fill with 1..F,0 and watch AlmostFull come up at 12.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 1'b0, 4'(i), 1'b0);
      #3;
      chk("fill_count", int'(Count), i - 1);
      chk("fill_afull", int'(AlmostFull), int'((i - 1) >= 12));
    end
    idle(1);
    #3;
    chk("fill_Full", int'(Full), 1);
    chk("fill_Count16", int'(Count), 16);

    // Drain; each word appears the cycle after its pop.
    for (int i = 1; i <= 16; i++) begin
      drive(1'b0, 1'b1, '0, 1'b0);
      #3;
      if (i > 1) begin
        chk("drain_valid", int'(PopValid), 1);
        chk("drain_data", int'(PopData), (i - 1) % 16);
      end
    end
    idle(1);
    #3;
    chk("drain_last_data", int'(PopData), 0);
    chk("drain_Empty", int'(Empty), 1);
    chk("drain_ParityErr", int'(ParityErr), 0);

    // Full + push&pop -> overflow; empty + push&pop -> underflow.
    for (int i = 0; i < 16; i++) drive(1'b1, 1'b0, 4'($urandom), 1'b0);
    drive(1'b1, 1'b1, 4'($urandom), 1'b0);
    idle(1);
    #3;
    chk("ovf_pulse", int'(Overflow), 1);
    chk("ovf_count", int'(Count), 15);
    for (int i = 0; i < 15; i++) drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b1, 1'b1, 4'($urandom), 1'b0);
    idle(1);
    #3;
    chk("unf_pulse", int'(Underflow), 1);
    chk("unf_count", int'(Count), 1);
    drive(1'b0, 1'b1, '0, 1'b0);
    idle(1);

    // Alternating push/pop across the pointer wrap.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 4'($urandom), 1'b0);
      drive(1'b0, 1'b1, '0, 1'b0);
      #3;
      chk("alt_count_le1", int'(Count <= 1), 1);
    end
    idle(1);

    // Corrupt one read's parity; error is sticky until Flush.
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 4'($urandom), 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0);
    @(negedge Clock);
    Push = 1'b0; Pop = 1'b0; flip_edo = 1'b1;
    @(negedge Clock);
    flip_edo = 1'b0;
    #3;
    chk("perr_set", int'(ParityErr), 1);
    idle(3);
    #3;
    chk("perr_sticky", int'(ParityErr), 1);
    drive(1'b0, 1'b0, '0, 1'b1);
    idle(1);
    #3;
    chk("flush_perr", int'(ParityErr), 0);
    chk("flush_count", int'(Count), 0);
    chk("flush_empty", int'(Empty), 1);

    // In-flight PopValid survives a Flush.
    drive(1'b1, 1'b0, 4'h9, 1'b0);
    drive(1'b0, 1'b1, '0, 1'b0);
    drive(1'b0, 1'b0, '0, 1'b1);
    #3;
    chk("flush_inflight_valid", int'(PopValid), 1);
    chk("flush_inflight_data", int'(PopData), 9);
    idle(1);

    // Asynchronous reset with seven words held.
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 4'($urandom), 1'b0);
    idle(1);
    #3;
    chk("pre_rst_count", int'(Count), 7);
    ResetN = 1'b0;
    #1;
    chk("arst_Busy", int'(Busy), 1);
    chk("arst_Count", int'(Count), 0);
    chk("arst_Full", int'(Full), 1);
    chk("arst_Empty", int'(Empty), 1);
    chk("arst_AFull", int'(AlmostFull), 0);
    @(negedge Clock);
    ResetN = 1'b1;
    idle(16);
    #3;
    chk("resweep_done", int'(Busy), 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      drive(1'($urandom), 1'($urandom), 4'($urandom), ($urandom_range(0, 31) == 0));
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
